keyboard_pad_decoder: RTL and testbench

KEYBOARD_PAD_DECODER -- requirements
Module: keyboard_pad_decoder

---
 rtl/keyboard_pad_decoder.sv | 137 +++++++++++++
 tb/tb_keyboard_pad_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_pad_decoder.sv
// PS/2 scan-code decoder: turns make/break sequences (with E0/F0 prefixes)
// into held pad commands for two players plus a one-cycle start request.
module keyboard_pad_decoder #(
   parameter logic [7:0] KEY_UP_P1      = 8'h1D,
   parameter logic [7:0] KEY_DOWN_P1    = 8'h1B,
   parameter logic [7:0] KEY_UP_P2      = 8'h75,
   parameter logic [7:0] KEY_DOWN_P2    = 8'h72,
   parameter logic [7:0] KEY_START      = 8'h29,
   parameter int         PREFIX_TIMEOUT = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       up_p1,
   output logic       down_p1,
   output logic       up_p2,
   output logic       down_p2,
   output logic       start_pulse,
   output logic [1:0] o_dbg_state
);

   localparam int CW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT) : 1;
   localparam logic [CW-1:0] TMAX = CW'(PREFIX_TIMEOUT - 1);

   localparam logic [7:0] BYTE_EXT = 8'hE0;
   localparam logic [7:0] BYTE_BRK = 8'hF0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      EXT     = 2'd1,
      BRK     = 2'd2,
      EXT_BRK = 2'd3
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_up1, r_dn1, r_up2, r_dn2, r_start, r_start_d;
   logic          w_up1_nxt, w_dn1_nxt, w_up2_nxt, w_dn2_nxt, w_start_nxt;
   logic          w_code, w_ext, w_brk;

   // rx_valid is a one-cycle strobe with no back-pressure: every strobe
   // carries exactly one byte and is consumed on that same clock edge.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_code      = 1'b0;
      w_ext       = 1'b0;
      w_brk       = 1'b0;
      w_up1_nxt   = r_up1;
      w_dn1_nxt   = r_dn1;
      w_up2_nxt   = r_up2;
      w_dn2_nxt   = r_dn2;
      w_start_nxt = r_start;

      if (rx_valid) begin
         w_cnt_nxt = '0;
         case (r_state)
            IDLE: begin
               if (rx_data == BYTE_EXT)      w_state_nxt = EXT;
               else if (rx_data == BYTE_BRK) w_state_nxt = BRK;
               else                          w_code      = 1'b1;
            end
            EXT: begin
               if (rx_data == BYTE_BRK) w_state_nxt = EXT_BRK;
               else if (rx_data != BYTE_EXT) begin
                  w_code      = 1'b1;
                  w_ext       = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            BRK: begin
               if (rx_data != BYTE_EXT && rx_data != BYTE_BRK) begin
                  w_code      = 1'b1;
                  w_brk       = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
            default: begin
               if (rx_data != BYTE_EXT && rx_data != BYTE_BRK) begin
                  w_code      = 1'b1;
                  w_ext       = 1'b1;
                  w_brk       = 1'b1;
                  w_state_nxt = IDLE;
               end
            end
         endcase
      end else if (r_state == IDLE) begin
         w_cnt_nxt = '0;
      end else if (r_cnt == TMAX) begin
         // Abandon a stale prefix; flags are deliberately left alone.
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
      end else begin
         w_cnt_nxt = r_cnt + 1'b1;
      end

      if (w_code) begin
         if (!w_ext && rx_data == KEY_UP_P1)   w_up1_nxt   = ~w_brk;
         if (!w_ext && rx_data == KEY_DOWN_P1) w_dn1_nxt   = ~w_brk;
         if ( w_ext && rx_data == KEY_UP_P2)   w_up2_nxt   = ~w_brk;
         if ( w_ext && rx_data == KEY_DOWN_P2) w_dn2_nxt   = ~w_brk;
         if (!w_ext && rx_data == KEY_START)   w_start_nxt = ~w_brk;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_up1     <= 1'b0;
         r_dn1     <= 1'b0;
         r_up2     <= 1'b0;
         r_dn2     <= 1'b0;
         r_start   <= 1'b0;
         r_start_d <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_up1     <= w_up1_nxt;
         r_dn1     <= w_dn1_nxt;
         r_up2     <= w_up2_nxt;
         r_dn2     <= w_dn2_nxt;
         r_start   <= w_start_nxt;
         r_start_d <= r_start;
      end
   end

   // Opposing keys of one player cancel; outputs are forced low during reset.
   assign up_p1       = ~rst & r_up1 & ~r_dn1;
   assign down_p1     = ~rst & r_dn1 & ~r_up1;
   assign up_p2       = ~rst & r_up2 & ~r_dn2;
   assign down_p2     = ~rst & r_dn2 & ~r_up2;
   assign start_pulse = ~rst & r_start & ~r_start_d;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_keyboard_pad_decoder.sv
// Bench for keyboard_pad_decoder: directed sequences plus random byte streams
// checked every cycle against a per-key held-state model.
module tb_keyboard_pad_decoder;

   localparam int         T   = 20;
   localparam logic [7:0] KU1 = 8'h1D;
   localparam logic [7:0] KD1 = 8'h1B;
   localparam logic [7:0] KU2 = 8'h75;
   localparam logic [7:0] KD2 = 8'h72;
   localparam logic [7:0] KST = 8'h29;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       up_p1, down_p1, up_p2, down_p2, start_pulse;
   logic [1:0] dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_strobe = 0;
   int pulses = 0;

   // Model: held status of every key code, separately for plain and E0 codes.
   bit held_n[256];
   bit held_e[256];
   bit pend_ext, pend_brk, exp_pulse;

   keyboard_pad_decoder #(
      .KEY_UP_P1(KU1), .KEY_DOWN_P1(KD1), .KEY_UP_P2(KU2),
      .KEY_DOWN_P2(KD2), .KEY_START(KST), .PREFIX_TIMEOUT(T)
   ) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
      .up_p1(up_p1), .down_p1(down_p1), .up_p2(up_p2), .down_p2(down_p2),
      .start_pulse(start_pulse), .o_dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int obs, input int exp);
      checks++;
      assert (obs == exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, "_up1"}, up_p1,   held_n[KU1] & ~held_n[KD1]);
      chk({tag, "_dn1"}, down_p1, held_n[KD1] & ~held_n[KU1]);
      chk({tag, "_up2"}, up_p2,   held_e[KU2] & ~held_e[KD2]);
      chk({tag, "_dn2"}, down_p2, held_e[KD2] & ~held_e[KU2]);
      chk({tag, "_start"}, start_pulse, exp_pulse);
      if (start_pulse === 1'b1) pulses++;
      exp_pulse = 1'b0;
   endtask

   task automatic model_byte(input logic [7:0] b);
      bit was_start;
      if ((pend_ext || pend_brk) && (cyc - last_strobe) > T) begin
         pend_ext = 1'b0;
         pend_brk = 1'b0;
      end
      last_strobe = cyc;
      if (b == 8'hE0) begin
         if (!pend_brk) pend_ext = 1'b1;
      end else if (b == 8'hF0) begin
         pend_brk = 1'b1;
      end else begin
         was_start = held_n[KST];
         if (pend_ext) held_e[b] = ~pend_brk;
         else          held_n[b] = ~pend_brk;
         if (!was_start && held_n[KST]) exp_pulse = 1'b1;
         pend_ext = 1'b0;
         pend_brk = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); cyc++;
         @(negedge clk);
         check_outputs("idle");
      end
   endtask

   task automatic send(input logic [7:0] b, input int gap);
      idle(gap);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); cyc++;
      model_byte(b);
      @(negedge clk);
      rx_valid = 1'b0;
      check_outputs($sformatf("byte_%h", b));
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < 256; i++) begin
         held_n[i] = 1'b0;
         held_e[i] = 1'b0;
      end
      pend_ext  = 1'b0;
      pend_brk  = 1'b0;
      exp_pulse = 1'b0;
      rst      = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'hE0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); cyc++;
         @(negedge clk);
         chk("rst_up1", up_p1, 1'b0);
         chk("rst_dn1", down_p1, 1'b0);
         chk("rst_up2", up_p2, 1'b0);
         chk("rst_dn2", down_p2, 1'b0);
         chk("rst_start", start_pulse, 1'b0);
      end
      rst      = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
   endtask

   function automatic logic [7:0] pick_byte();
      case ($urandom_range(0, 11))
         0:       return KU1;
         1:       return KD1;
         2:       return KU2;
         3:       return KD2;
         4:       return KST;
         5, 6:    return 8'hE0;
         7, 8:    return 8'hF0;
         9:       return 8'hE1;
         10:      return 8'hAA;
         default: return 8'($urandom_range(0, 255));
      endcase
   endfunction

   initial begin
      int p0;
      int gap;
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      do_reset(3);
      idle(2);

      // Make then break of player 1 up.
      send(KU1, 1);   chk("r28_up_on", up_p1, 1'b1);
      send(8'hF0, 1); chk("r28_up_hold", up_p1, 1'b1);
      send(KU1, 0);   chk("r28_up_off", up_p1, 1'b0);

      // Extended vs plain class separation.
      send(8'hE0, 1); send(KD2, 0); chk("r29_dn2", down_p2, 1'b1);
      send(KD1, 1);   chk("r29_dn1", down_p1, 1'b1);
      send(KD2, 1);   chk("r29_dn2_keep", down_p2, 1'b1);
      chk("r29_up2_none", up_p2, 1'b0);
      send(8'hE0, 1); send(8'hF0, 0); send(KD2, 0);
      chk("r29_dn2_rel", down_p2, 1'b0);
      send(8'hF0, 1); send(KD1, 0);
      send(8'hF0, 1); send(KD2, 0);

      // Both keys of one player cancel.
      send(KU1, 1); send(KD1, 1);
      chk("r30_up1_cancel", up_p1, 1'b0);
      chk("r30_dn1_cancel", down_p1, 1'b0);
      send(8'hF0, 1); send(KU1, 0);
      chk("r30_dn1_alone", down_p1, 1'b1);
      send(8'hF0, 1); send(KD1, 0);

      // Start pulse: typematic repeats give no extra pulse.
      p0 = pulses;
      send(KST, 1); send(KST, 1); send(KST, 1);
      send(8'hF0, 1); send(KST, 0);
      send(KST, 2); idle(3);
      chk_int("r31_pulses", pulses - p0, 2);
      send(8'hF0, 1); send(KST, 0);

      // Stale E0 prefix times out; 75 then decodes as a plain code.
      send(8'hE0, 1); send(KU2, T + 5);
      chk("r32_up2_timeout", up_p2, 1'b0);
      send(8'hF0, 1); send(KU2, 0);

      // Reset in the middle of a prefix sequence discards the prefix.
      send(8'hE0, 1); send(KU2, 0); chk("r33_up2_on", up_p2, 1'b1);
      send(8'hE0, 1);
      do_reset(1);
      chk("r33_up2_rst", up_p2, 1'b0);
      send(KU2, 1);
      chk("r33_up2_after", up_p2, 1'b0);

      // Random byte streams, occasional long gaps and resets.
      for (int n = 0; n < 400; n++) begin
         gap = ($urandom_range(0, 29) == 0) ? T + 6 : int'($urandom_range(0, 3));
         if ($urandom_range(0, 59) == 0) do_reset(1);
         send(pick_byte(), gap);
      end
      idle(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
